// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: thermometer stall vector from per-stage
// stall requests plus a two-state RUN/FLUSH sequencer that redirects the PC.
// Latency: stall is combinational; flush/busy/new_pc rise 1 cycle after an
//   accepted flush_req and hold for FLUSH_CYCLES cycles.
// Backpressure: flush_req is ignored while a flush is in progress; a stall
//   never blocks a flush, and stall is forced low during the flush.
//
// Ports:
//   clk, rst       single clock, asynchronous active-high reset
//   stallreq       per-stage stall request (bit 0 = PC ... bit 5 = WB)
//   flush_req      exception/redirect request, exc_pc = its target
//   stall          stall vector: all stages at or below the highest requester
//   flush, busy    high exactly while the sequencer is in FLUSH
//   new_pc         latched redirect target, held until the next accepted flush
//   stall_timeout  sticky watchdog flag (tied low unless the watchdog is built)
//
// Build option: define PIPE_CTRL_WDOG_EN to include the stall watchdog that
// counts consecutive stalled cycles and trips at STALL_LIMIT.

module pipe_ctrl #(
  parameter int STAGES       = 6,
  parameter int AW           = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_LIMIT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              flush_req,
  input  logic [AW-1:0]     exc_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [AW-1:0]     new_pc,
  output logic              busy,
  output logic              stall_timeout
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [AW-1:0]     r_new_pc;
  logic [AW-1:0]     w_new_pc_nxt;
  logic [STAGES-1:0] w_stall_raw;

  // Stage i stalls when it or any later stage requests a stall, which yields
  // ones from bit 0 up to the highest requester.
  always_comb begin
    w_stall_raw = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_stall_raw[i] = |(stallreq >> i);
    end
  end

  // rst gates stall combinationally so it is low during reset without a clock.
  assign stall = (rst || (r_state == FLUSH)) ? '0 : w_stall_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_new_pc <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_new_pc <= w_new_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_new_pc_nxt = r_new_pc;
    unique case (r_state)
      RUN: begin
        if (flush_req) begin
          w_state_nxt  = FLUSH;
          w_cnt_nxt    = FLUSH_LOAD;
          w_new_pc_nxt = exc_pc;
        end
      end
      FLUSH: begin
        // Counter holds remaining cycles after this one; flush_req is ignored.
        if (r_cnt == 4'd0) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign flush  = (r_state == FLUSH);
  assign busy   = (r_state == FLUSH);
  assign new_pc = r_new_pc;

`ifdef PIPE_CTRL_WDOG_EN
  localparam int             WW    = $clog2(STALL_LIMIT + 1);
  localparam logic [WW-1:0]  LIMIT = WW'(STALL_LIMIT);

  logic [WW-1:0] r_wdog;
  logic [WW-1:0] w_wdog_nxt;
  logic          r_timeout;

  always_comb begin
    w_wdog_nxt = r_wdog;
    if (stall == '0) begin
      w_wdog_nxt = '0;
    end else if (r_wdog != LIMIT) begin
      w_wdog_nxt = r_wdog + 1'b1;
    end
  end

  // The flag rises on the same edge the counter reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wdog    <= w_wdog_nxt;
      r_timeout <= r_timeout | (w_wdog_nxt == LIMIT);
    end
  end

  assign stall_timeout = r_timeout;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: vector table, hand-written corner sequences and
// randomized traffic checked against a behavioural model.
module tb_pipe_ctrl;

  localparam int FC  = 3;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq;
  logic        flush_req;
  logic [31:0] exc_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
  logic        stall_timeout;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .STAGES(6), .AW(32), .FLUSH_CYCLES(FC), .STALL_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .exc_pc(exc_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .busy(busy), .stall_timeout(stall_timeout)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: remaining flush cycles, latched target,
  // consecutive-stall count and sticky timeout.
  int          m_left;
  logic [31:0] m_pc;
  int          m_wd;
  bit          m_to;

  typedef struct {
    logic [5:0]  sr;
    logic        fr;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [5:0] therm(input logic [5:0] r);
    int k;
    k = -1;
    for (int i = 0; i < 6; i++) if (r[i]) k = i;
    if (k < 0) return 6'd0;
    return 6'((1 << (k + 1)) - 1);
  endfunction

  function automatic logic [5:0] exp_stall();
    if (rst || m_left > 0) return 6'd0;
    return therm(stallreq);
  endfunction

  function automatic logic exp_to();
`ifdef PIPE_CTRL_WDOG_EN
    return m_to;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_zero();
    m_left = 0;
    m_pc   = '0;
    m_wd   = 0;
    m_to   = 0;
  endtask

  task automatic drive(input logic r, input logic [5:0] sr, input logic fr, input logic [31:0] pc);
    @(negedge clk);
    rst       = r;
    stallreq  = sr;
    flush_req = fr;
    exc_pc    = pc;
    if (r) model_zero();
    #1;
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".stall"},   {26'd0, stall},   {26'd0, exp_stall()});
    chk({tag, ".flush"},   {31'd0, flush},   {31'd0, (m_left > 0)});
    chk({tag, ".busy"},    {31'd0, busy},    {31'd0, (m_left > 0)});
    chk({tag, ".new_pc"},  new_pc,           m_pc);
    chk({tag, ".timeout"}, {31'd0, stall_timeout}, {31'd0, exp_to()});
  endtask

  // Advance one clock edge and update the model with the inputs held across it.
  task automatic edge_update();
    logic [5:0] s;
    s = exp_stall();
    @(posedge clk);
    if (rst) begin
      model_zero();
    end else begin
      if (s != 0) m_wd = (m_wd + 1 > LIM) ? LIM : m_wd + 1;
      else        m_wd = 0;
      if (m_wd == LIM) m_to = 1;
      if (m_left > 0) begin
        m_left--;
      end else if (flush_req) begin
        m_left = FC;
        m_pc   = exc_pc;
      end
    end
  endtask

  task automatic step(input logic r, input logic [5:0] sr, input logic fr, input logic [31:0] pc,
                      input string tag);
    drive(r, sr, fr, pc);
    model_check(tag);
    edge_update();
  endtask

  initial begin
    rst = 1'b1; stallreq = 6'b111111; flush_req = 1'b1; exc_pc = 32'hFFFF_FFFF;
    model_zero();

    // Reset state, with every stage requesting a stall.
    step(1'b1, 6'b111111, 1'b1, 32'hFFFF_FFFF, "reset0");
    step(1'b1, 6'b111111, 1'b1, 32'hFFFF_FFFF, "reset1");

    // stall patterns, flush of 3 cycles, ignored re-requests, stall held during flush
    vecs[0] = '{6'b000100, 1'b0, 32'h0,  6'b000111, 1'b0, 32'h0};
    vecs[1] = '{6'b001100, 1'b0, 32'h0,  6'b001111, 1'b0, 32'h0};
    vecs[2] = '{6'b000000, 1'b0, 32'h0,  6'b000000, 1'b0, 32'h0};
    vecs[3] = '{6'b001000, 1'b1, 32'h40, 6'b001111, 1'b0, 32'h0};
    vecs[4] = '{6'b001000, 1'b0, 32'h0,  6'b000000, 1'b1, 32'h40};
    vecs[5] = '{6'b001000, 1'b1, 32'h80, 6'b000000, 1'b1, 32'h40};
    vecs[6] = '{6'b001000, 1'b1, 32'h80, 6'b000000, 1'b1, 32'h40};
    vecs[7] = '{6'b001000, 1'b0, 32'h0,  6'b001111, 1'b0, 32'h40};
    vecs[8] = '{6'b000000, 1'b0, 32'h0,  6'b000000, 1'b0, 32'h40};
    for (int v = 0; v < 9; v++) begin
      drive(1'b0, vecs[v].sr, vecs[v].fr, vecs[v].pc);
      chk($sformatf("vec%0d.stall", v),  {26'd0, stall}, {26'd0, vecs[v].e_stall});
      chk($sformatf("vec%0d.flush", v),  {31'd0, flush}, {31'd0, vecs[v].e_flush});
      chk($sformatf("vec%0d.busy", v),   {31'd0, busy},  {31'd0, vecs[v].e_flush});
      chk($sformatf("vec%0d.new_pc", v), new_pc,         vecs[v].e_pc);
      chk($sformatf("vec%0d.timeout", v), {31'd0, stall_timeout}, 32'd0);
      edge_update();
    end

    // Watchdog: 3 stalled, 1 free, 4 stalled.
    step(1'b1, 6'b0, 1'b0, 32'h0, "wd_rst");
    for (int i = 0; i < 3; i++) step(1'b0, 6'b000001, 1'b0, 32'h0, "wd_b1");
    drive(1'b0, 6'b0, 1'b0, 32'h0);
    chk("wd_after_burst1", {31'd0, stall_timeout}, 32'd0);
    edge_update();
    for (int i = 0; i < 4; i++) step(1'b0, 6'b000010, 1'b0, 32'h0, "wd_b2");
    drive(1'b0, 6'b0, 1'b0, 32'h0);
`ifdef PIPE_CTRL_WDOG_EN
    chk("wd_trip", {31'd0, stall_timeout}, 32'd1);
`else
    chk("wd_absent", {31'd0, stall_timeout}, 32'd0);
`endif
    edge_update();
    drive(1'b0, 6'b0, 1'b0, 32'h0);
`ifdef PIPE_CTRL_WDOG_EN
    chk("wd_sticky", {31'd0, stall_timeout}, 32'd1);
`else
    chk("wd_absent2", {31'd0, stall_timeout}, 32'd0);
`endif
    edge_update();
    drive(1'b1, 6'b0, 1'b0, 32'h0);
    chk("wd_clear_rst", {31'd0, stall_timeout}, 32'd0);
    edge_update();

    // Asynchronous reset in the middle of a flush.
    step(1'b0, 6'b0, 1'b1, 32'hDEAD_BEE0, "af_req");
    drive(1'b0, 6'b111111, 1'b0, 32'h0);
    chk("af_flush_on", {31'd0, flush}, 32'd1);
    chk("af_pc_on",    new_pc,         32'hDEAD_BEE0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_zero();
    #1;
    chk("af_flush_off", {31'd0, flush}, 32'd0);
    chk("af_busy_off",  {31'd0, busy},  32'd0);
    chk("af_pc_off",    new_pc,         32'd0);
    chk("af_stall_off", {26'd0, stall}, 32'd0);
    step(1'b1, 6'b111111, 1'b0, 32'h0, "af_hold");
    step(1'b0, 6'b000000, 1'b0, 32'h0, "af_run");

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      logic       r;
      logic [5:0] sr;
      logic       fr;
      r  = ($urandom_range(0, 99) == 0);
      sr = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
      fr = ($urandom_range(0, 5) == 0);
      step(r, sr, fr, $urandom, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
